// File: rtl/regfile_read_port_pkg.sv
// Shared CPU constants for the register-file read stage.
// Also holds the operand-latch state type and the write-back bypass hit test.
package regfile_read_port_pkg;

   localparam int unsigned CPU_DATA_WIDTH = 32;
   localparam int unsigned CPU_NUM_REGS   = 32;
   localparam int unsigned CPU_ADDR_WIDTH = 5;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } latch_state_e;

   // Register 0 is hard-wired to zero, so a write-back to it never forwards.
   function automatic logic bypass_hit(
      input logic [CPU_ADDR_WIDTH-1:0] rd_addr,
      input logic                      wb_we,
      input logic [CPU_ADDR_WIDTH-1:0] wb_addr
   );
      return wb_we && (wb_addr != '0) && (wb_addr == rd_addr);
   endfunction

endpackage

// File: rtl/regfile_read_port_decoder_5to32.sv
// One-hot read-enable decoder with a gating enable; all zeros when disabled.
module decoder_5to32
   import regfile_read_port_pkg::*;
#(
   parameter int unsigned OUT_WIDTH = CPU_NUM_REGS
) (
   input  logic                      en,
   input  logic [CPU_ADDR_WIDTH-1:0] addr,
   output logic [OUT_WIDTH-1:0]      dec
);

   always_comb begin
      dec = '0;
      if (en) begin
         dec[addr] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_read_port.sv
// Register-file read port: drives the array read enables, applies the zero
// register and write-back bypass, and holds the operands in a handshake latch.
module regfile_read_port
   import regfile_read_port_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CPU_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = CPU_NUM_REGS
) (
   input  logic                      clock,
   input  logic                      clear,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CPU_ADDR_WIDTH-1:0] addrA,
   input  logic [CPU_ADDR_WIDTH-1:0] addrB,
   output logic [NUM_REGS-1:0]       readAen,
   output logic [NUM_REGS-1:0]       readBen,
   input  logic [DATA_WIDTH-1:0]     busA,
   input  logic [DATA_WIDTH-1:0]     busB,
   input  logic                      wb_we,
   input  logic [CPU_ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0]     wb_data,
   input  logic                      flush,
   output logic                      out_valid,
   output logic [DATA_WIDTH-1:0]     out_opA,
   output logic [DATA_WIDTH-1:0]     out_opB,
   input  logic                      out_ready
);

   latch_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
   logic [DATA_WIDTH-1:0] op_b_q, op_b_d;

   logic                  fire_c;
   logic                  en_a_c, en_b_c;
   logic [DATA_WIDTH-1:0] sel_a_c, sel_b_c;

   assign out_valid = (state_q == ST_FULL);
   assign out_opA   = op_a_q;
   assign out_opB   = op_b_q;

   assign in_ready  = ~out_valid | out_ready;
   assign fire_c    = in_valid & in_ready;

   // Only a live, non-zero request may turn on a tristate driver.
   assign en_a_c = fire_c & (addrA != '0) & ~clear;
   assign en_b_c = fire_c & (addrB != '0) & ~clear;

   decoder_5to32 #(
      .OUT_WIDTH (NUM_REGS)
   ) u_dec_a (
      .en   (en_a_c),
      .addr (addrA),
      .dec  (readAen)
   );

   decoder_5to32 #(
      .OUT_WIDTH (NUM_REGS)
   ) u_dec_b (
      .en   (en_b_c),
      .addr (addrB),
      .dec  (readBen)
   );

   // Operand select: zero register, then write-back forward, then array bus.
   always_comb begin
      sel_a_c = busA;
      sel_b_c = busB;
      if (addrA == '0) begin
         sel_a_c = '0;
      end else if (bypass_hit(addrA, wb_we, wb_addr)) begin
         sel_a_c = wb_data;
      end
      if (addrB == '0) begin
         sel_b_c = '0;
      end else if (bypass_hit(addrB, wb_we, wb_addr)) begin
         sel_b_c = wb_data;
      end
   end

   // Latch next state: capture on fire, drain on consume, flush wins.
   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;

      if (fire_c) begin
         op_a_d = sel_a_c;
         op_b_d = sel_b_c;
      end

      case (state_q)
         ST_EMPTY: begin
            if (fire_c) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (fire_c) begin
               state_d = ST_FULL;
            end else if (out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      if (flush) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= ST_EMPTY;
         op_a_q  <= '0;
         op_b_q  <= '0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
      end
   end

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: expected operands queue per fire,
// a negedge monitor pops them whenever the latch is consumed.
module tb_regfile_read_port;

   logic        clock = 1'b0;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  addrA, addrB;
   logic [31:0] readAen, readBen;
   logic [31:0] busA, busB;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic [31:0] out_opA, out_opB;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;
   exp_t exp_q[$];

   always #5 clock = ~clock;

   regfile_read_port dut (
      .clock     (clock),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .addrA     (addrA),
      .addrB     (addrB),
      .readAen   (readAen),
      .readBen   (readBen),
      .busA      (busA),
      .busB      (busB),
      .wb_we     (wb_we),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_opA   (out_opA),
      .out_opB   (out_opB),
      .out_ready (out_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic req(input logic v, input logic [4:0] aa, input logic [31:0] ba,
                      input logic [4:0] ab, input logic [31:0] bb);
      in_valid = v;
      addrA    = aa;
      busA     = ba;
      addrB    = ab;
      busB     = bb;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: a consumed latch must match the oldest expectation.
   always @(negedge clock) begin
      if (!clear && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_opA", out_opA, e.a);
            chk("sb_opB", out_opB, e.b);
         end
      end
   end

   initial begin
      clear     = 1'b1;
      flush     = 1'b0;
      wb_we     = 1'b0;
      wb_addr   = '0;
      wb_data   = '0;
      out_ready = 1'b1;
      req(1'b1, 5'd5, 32'h1, 5'd6, 32'h2);
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_opA", out_opA, 32'd0);
      chk("rst_readAen", readAen, 32'd0);
      chk("rst_readBen", readBen, 32'd0);
      cyc();
      clear = 1'b0;
      req(1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      cyc();

      // Plain fire with zero register on B.
      req(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 32'hFFFFFFFF);
      #2;
      chk("fire_in_ready", 32'(in_ready), 32'd1);
      chk("fire_readAen", readAen, 32'h00000020);
      chk("fire_readBen", readBen, 32'h00000000);
      push(32'hDEADBEEF, 32'h0);
      cyc();
      req(1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      #2;
      chk("fire_out_valid", 32'(out_valid), 32'd1);
      chk("fire_opA_direct", out_opA, 32'hDEADBEEF);

      // Bypass cases, back to back.
      cyc();
      wb_we   = 1'b1;
      wb_addr = 5'd7;
      wb_data = 32'h12345678;
      req(1'b1, 5'd7, 32'hAAAAAAAA, 5'd3, 32'h00000033);
      push(32'h12345678, 32'h00000033);
      cyc();
      wb_addr = 5'd0;
      req(1'b1, 5'd0, 32'hAAAAAAAA, 5'd9, 32'h00000099);
      push(32'h0, 32'h00000099);
      #2;
      chk("zero_readAen", readAen, 32'h0);
      chk("zero_readBen", readBen, 32'h00000200);
      cyc();
      req(1'b1, 5'd4, 32'h00000044, 5'd7, 32'h00000077);
      push(32'h00000044, 32'h00000077);
      cyc();
      wb_addr = 5'd7;
      wb_data = 32'hCAFEF00D;
      req(1'b1, 5'd6, 32'h00000066, 5'd7, 32'h00000077);
      push(32'h00000066, 32'hCAFEF00D);
      cyc();
      wb_we = 1'b0;

      // Stall: latch held for three cycles, upstream blocked.
      req(1'b1, 5'd10, 32'h10101010, 5'd11, 32'h11111111);
      push(32'h10101010, 32'h11111111);
      cyc();
      out_ready = 1'b0;
      req(1'b1, 5'd12, 32'hBADBAD00, 5'd13, 32'hBADBAD01);
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_readAen", readAen, 32'h0);
         chk("stall_readBen", readBen, 32'h0);
         chk("stall_opA", out_opA, 32'h10101010);
         chk("stall_opB", out_opB, 32'h11111111);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         cyc();
      end
      out_ready = 1'b1;
      req(1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      cyc();
      #2;
      chk("drain_out_valid", 32'(out_valid), 32'd0);

      // Back-to-back fires, no bubbles.
      for (int i = 1; i <= 3; i++) begin
         req(1'b1, 5'(i), 32'h100 + 32'(i), 5'(i + 16), 32'h200 + 32'(i));
         push(32'h100 + 32'(i), 32'h200 + 32'(i));
         cyc();
         #2;
         chk("b2b_out_valid", 32'(out_valid), 32'd1);
         chk("b2b_opA_direct", out_opA, 32'h100 + 32'(i));
         #(-2 + 2);
      end
      req(1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      cyc();

      // Flush with fire from empty: request consumed, nothing captured.
      flush = 1'b1;
      req(1'b1, 5'd2, 32'h22222222, 5'd3, 32'h33333333);
      #2;
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_readAen", readAen, 32'h00000004);
      cyc();
      flush = 1'b0;
      req(1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      #2;
      chk("flush_out_valid", 32'(out_valid), 32'd0);

      // Flush during a stall kills the held operands.
      cyc();
      req(1'b1, 5'd8, 32'h88888888, 5'd9, 32'h99999999);
      cyc();
      out_ready = 1'b0;
      flush     = 1'b1;
      req(1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      cyc();
      flush     = 1'b0;
      out_ready = 1'b1;
      #2;
      chk("flush_stall_out_valid", 32'(out_valid), 32'd0);

      // Clear mid-stall.
      cyc();
      req(1'b1, 5'd5, 32'h55555555, 5'd6, 32'h66666666);
      cyc();
      out_ready = 1'b0;
      req(1'b1, 5'd7, 32'h77777777, 5'd1, 32'h11111111);
      #1;
      chk("pre_clear_out_valid", 32'(out_valid), 32'd1);
      clear = 1'b1;
      #1;
      chk("clear_out_valid", 32'(out_valid), 32'd0);
      chk("clear_opA", out_opA, 32'h0);
      chk("clear_opB", out_opB, 32'h0);
      chk("clear_readAen", readAen, 32'h0);
      chk("clear_readBen", readBen, 32'h0);
      cyc();
      clear = 1'b0;
      req(1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      #2;
      chk("post_clear_in_ready", 32'(in_ready), 32'd1);
      chk("post_clear_out_valid", 32'(out_valid), 32'd0);
      cyc();
      cyc();

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_read_port.md
REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of every register and of each read bus.
REQ-002 SHALL have parameter NUM_REGS, default 32, number of registers addressed; the address is 5 bits wide.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port clear, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a decode request is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the request this cycle.
REQ-007 SHALL have ports addrA and addrB, input, 5 bits each: source register numbers.
REQ-008 SHALL have ports readAen and readBen, output, 32 bits each: one-hot tristate read enables to the register array.
REQ-009 SHALL have ports busA and busB, input, 32 bits each: shared tristate read buses from the register array.
REQ-010 SHALL have ports wb_we (1 bit), wb_addr (5 bits) and wb_data (32 bits), inputs: the write-back port being written this cycle.
REQ-011 SHALL have port flush, input, 1 bit: synchronous kill of the captured operands.
REQ-012 SHALL have ports out_valid (1 bit) and out_opA and out_opB (32 bits each), outputs: the registered operand latch.
REQ-013 SHALL have port out_ready, input, 1 bit: the downstream stage consumes the operand latch.

Function
REQ-014 A request SHALL be accepted ("fire") in any cycle where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL equal (not out_valid) or out_ready, combinationally.
REQ-016 readAen SHALL equal the one-hot decode of addrA only in fire cycles with addrA != 0; otherwise it SHALL be all zeros. readBen SHALL follow the same rule using addrB.
REQ-017 At most one bit of each enable vector SHALL ever be 1, so that no two registers drive a bus at once.
REQ-018 The selected A operand SHALL be 0 when addrA = 0.
REQ-019 When addrA != 0, wb_we = 1 and wb_addr = addrA, the selected A operand SHALL be wb_data (write-back bypass).
REQ-020 In all other cases the selected A operand SHALL be busA.
REQ-021 REQ-018 to REQ-020 SHALL apply identically to the B operand, using addrB and busB.
REQ-022 On a fire edge, out_opA and out_opB SHALL capture the selected operands and out_valid SHALL become 1 (latency 1 cycle).
REQ-023 On an edge with out_valid = 1, out_ready = 1 and no fire, out_valid SHALL become 0.
REQ-024 While out_valid = 1 and out_ready = 0, out_valid, out_opA and out_opB SHALL hold, and in_ready SHALL be 0.
REQ-025 On an edge where fire and consumption happen together, the new operands SHALL replace the old ones with no bubble.
REQ-026 flush = 1 SHALL force out_valid to 0 at the next edge, overriding fire and stall. The request presented in that cycle is still considered consumed.
REQ-027 The state machine SHALL have two states, EMPTY (out_valid = 0) and FULL (out_valid = 1), with transitions as set by REQ-022 to REQ-026.
REQ-028 The bypass SHALL compare all 5 address bits. wb_addr = 0 SHALL never bypass.

Reset
REQ-029 While clear = 1, out_valid, out_opA and out_opB SHALL be 0 immediately, independent of clock.
REQ-030 While clear = 1, readAen and readBen SHALL be all zeros.
REQ-031 Asserting clear mid-stall SHALL discard the held operands; the first edge after deassertion SHALL behave as EMPTY.

Structure
REQ-032 DATA_WIDTH, NUM_REGS and the address width constant (5) SHALL live in the shared CPU constants package.
REQ-033 The two one-hot decodes SHALL be two instances of one sub-module, decoder_5to32, which has an enable input.
REQ-034 The operand latch SHALL be the only sequential logic; bypass and select SHALL be combinational.

Verification
REQ-035 Stimulus: clear=1 mid-stall with out_valid=1. Required: outputs and enables are 0 at once; after release, in_ready=1.
REQ-036 Stimulus: addrA=5, busA=0xDEADBEEF, addrB=0, busB=0xFFFFFFFF, fire. Required: readAen=0x00000020 and readBen=0 that cycle; next edge out_opA=0xDEADBEEF, out_opB=0, out_valid=1.
REQ-037 Stimulus: addrA=7, wb_we=1, wb_addr=7, wb_data=0x12345678, busA=0xAAAAAAAA. Required: out_opA=0x12345678. Repeat with wb_addr=0 and addrA=0. Required: out_opA=0.
REQ-038 Stimulus: out_valid=1 and out_ready=0 for 3 cycles while in_valid=1. Required: in_ready=0 and enables=0 throughout; out_opA/out_opB unchanged.
REQ-039 Stimulus: back-to-back fires with out_ready=1 and addresses 1,2,3. Required: out_opA follows busA of each request with one-cycle latency and out_valid stays 1.
REQ-040 Stimulus: flush=1 together with fire. Required: out_valid=0 at the next edge.
